e203_ifu_fetch_seq: RTL and testbench
=====================================

E203_IFU_FETCH_SEQ -- requirements
Module: e203_ifu_fetch_seq

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, width of all PC and address ports.
REQ-002 SHALL have parameter RFIDX_WIDTH, default 5, register-index width of dec_jalr_rs1idx.
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have pc_rtvec  input  PC_SIZE  reset fetch address, sampled on first cycle after reset release.
REQ-006 SHALL have ifu_req_valid/ifu_req_ready  output/input  1/1  fetch request handshake; ifu_req_pc  output  PC_SIZE  request address.
REQ-007 SHALL have ifu_rsp_valid/ifu_rsp_ready  input/output  1/1  response handshake; ifu_rsp_instr  input  32  fetched instruction; ifu_rsp_err  input  1  bus error.
REQ-008 SHALL have decoder inputs from mini-decoder on ifu_rsp_instr: dec_rv32, dec_jal, dec_jalr, dec_bxx  input  1; dec_jalr_rs1idx  input  RFIDX_WIDTH; dec_bjp_imm  input  PC_SIZE.
REQ-009 SHALL have jalr_rs1_val  input  PC_SIZE  value of register dec_jalr_rs1idx; jalr_rs1_dep  input  1  that value not yet valid.
REQ-010 SHALL have pipe_flush_req  input  1; pipe_flush_pc  input  PC_SIZE; pipe_flush_ack  output  1.
REQ-011 SHALL have ifu_o_valid/ifu_o_ready  output/input  1/1; ifu_o_ir  output  32; ifu_o_pc  output  PC_SIZE; ifu_o_prdt_taken, ifu_o_buserr  output  1.

Function
REQ-012 SHALL keep at most one fetch request outstanding.
REQ-013 SHALL implement states RST_FETCH, REQ, WAIT_RSP, WAIT_DEP, DRAIN.
REQ-014 RST_FETCH: one cycle after reset release, loads pc_rtvec as next PC, goes to REQ.
REQ-015 REQ: ifu_req_valid=1 with ifu_req_pc=next PC; on req handshake -> WAIT_RSP, latches request PC.
REQ-016 WAIT_RSP: ifu_rsp_ready=1 only when IR register empty or ifu_o_ready=1 same cycle; on rsp handshake loads IR, pc, err into output register and computes next PC.
REQ-017 Next PC (all sums mod 2^PC_SIZE): dec_jal -> pc+imm, taken; dec_bxx with imm MSB=1 -> pc+imm, taken; dec_bxx with MSB=0 -> sequential, not taken; dec_jalr rs1idx=0 -> imm, taken; dec_jalr rs1idx!=0 -> jalr_rs1_val+imm, taken; otherwise sequential.
REQ-018 Sequential = pc+4 if dec_rv32 else pc+2.
REQ-019 ifu_rsp_err=1 -> decoder inputs ignored, sequential next PC, ifu_o_buserr=1, ifu_o_prdt_taken=0.
REQ-020 dec_jalr, rs1idx!=0, jalr_rs1_dep=1 at response -> WAIT_DEP; target computed on first cycle dep=0, then REQ.
REQ-021 Non-waiting response -> REQ, new request earliest next cycle (one bubble).
REQ-022 ifu_o_valid set on IR load, cleared on ifu_o_valid&ifu_o_ready without new load; IR contents held while valid and not ready.
REQ-023 pipe_flush_req has priority over all events same cycle: pipe_flush_ack=1 combinationally, next PC=pipe_flush_pc, ifu_o_valid cleared, any same-cycle response dropped.
REQ-024 Flush while request handshaken but no response yet -> DRAIN; next response consumed (ifu_rsp_ready=1) and discarded, then REQ.
REQ-025 Flush in REQ, WAIT_DEP, or with response arriving same cycle -> REQ directly.
REQ-026 Flush in DRAIN -> updates next PC only, remains DRAIN.
REQ-027 Flush coincident with req handshake in REQ -> treated as outstanding, DRAIN.

Reset
REQ-028 During reset: state RST_FETCH, ifu_req_valid=0, ifu_rsp_ready=0, ifu_o_valid=0, ifu_o_ir=0, ifu_o_pc=0, prdt_taken=0, buserr=0, pipe_flush_ack=0.
REQ-029 Reset asserted mid-transaction -> all state cleared immediately; pending response after release not awaited.

Verification
REQ-030 pc_rtvec=0x8000_0000, 32-bit non-branch responses, ifu_o_ready=1 -> req PCs 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-031 At pc 0x100: bxx imm=0xFFFF_FFF0 -> next req 0x0F0, prdt_taken=1; bxx imm=0x10 -> next req 0x104 (rv32) or 0x102 (rv16), taken=0.
REQ-032 jalr rs1idx=1, dep=1 for 3 cycles, val=0x2000, imm=8 -> no request during dep; then req 0x2008.
REQ-033 Flush pc 0x4000 while in WAIT_RSP -> ack same cycle, next response discarded, ifu_o_valid stays 0, next req 0x4000.
REQ-034 ifu_o_ready=0 with IR full -> ifu_rsp_ready=0, IR stable; ifu_rsp_err=1 response -> buserr=1, sequential next PC.

Source files
------------

// File: rtl/e203_ifu_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : e203_ifu_fetch_seq
// Purpose  : Instruction-fetch sequencer. Issues one fetch request at a time,
//            captures the response into an output IR register and computes
//            the next fetch PC with static prediction. Backward branches are
//            predicted taken. jal/jalr are always taken. Pipeline flushes
//            redirect fetch and discard any in-flight response.
// Ports    :
//   clk, rst_n            - clock, asynchronous active-low reset
//   pc_rtvec              - reset fetch address (sampled once after reset)
//   ifu_req_*             - fetch request handshake and address
//   ifu_rsp_*             - fetch response handshake, instruction, bus error
//   dec_*                 - mini-decoder results for ifu_rsp_instr
//   jalr_rs1_val/_dep     - jalr base register value and its pending flag
//   pipe_flush_*          - redirect request, target PC, acknowledge
//   ifu_o_*               - fetched instruction toward the decode stage
// Revision : 1.0 - initial release
// ============================================================================
module e203_ifu_fetch_seq #(
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_SIZE-1:0]     pc_rtvec,
  // fetch request channel
  output logic                   ifu_req_valid,
  input  logic                   ifu_req_ready,
  output logic [PC_SIZE-1:0]     ifu_req_pc,
  // fetch response channel
  input  logic                   ifu_rsp_valid,
  output logic                   ifu_rsp_ready,
  input  logic [31:0]            ifu_rsp_instr,
  input  logic                   ifu_rsp_err,
  // mini-decoder results for ifu_rsp_instr
  input  logic                   dec_rv32,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic [PC_SIZE-1:0]     dec_bjp_imm,
  // jalr base register
  input  logic [PC_SIZE-1:0]     jalr_rs1_val,
  input  logic                   jalr_rs1_dep,
  // pipeline flush
  input  logic                   pipe_flush_req,
  input  logic [PC_SIZE-1:0]     pipe_flush_pc,
  output logic                   pipe_flush_ack,
  // output toward decode
  output logic                   ifu_o_valid,
  input  logic                   ifu_o_ready,
  output logic [31:0]            ifu_o_ir,
  output logic [PC_SIZE-1:0]     ifu_o_pc,
  output logic                   ifu_o_prdt_taken,
  output logic                   ifu_o_buserr
);

  typedef enum logic [2:0] {
    RST_FETCH = 3'd0,
    REQ       = 3'd1,
    WAIT_RSP  = 3'd2,
    WAIT_DEP  = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  localparam logic [PC_SIZE-1:0] c_pc_inc4 = PC_SIZE'(4);
  localparam logic [PC_SIZE-1:0] c_pc_inc2 = PC_SIZE'(2);

  state_t               r_state;
  logic [PC_SIZE-1:0]   r_next_pc;   // address of the next request to issue
  logic [PC_SIZE-1:0]   r_req_pc;    // address of the outstanding request
  logic [PC_SIZE-1:0]   r_dep_imm;   // jalr offset held while rs1 is pending
  logic                 r_o_valid;
  logic [31:0]          r_o_ir;
  logic [PC_SIZE-1:0]   r_o_pc;
  logic                 r_o_taken;
  logic                 r_o_buserr;

  logic                 w_req_hs;
  logic                 w_rsp_hs;
  logic                 w_flush;
  logic                 w_rsp_ready;
  logic [PC_SIZE-1:0]   w_seq_pc;
  logic [PC_SIZE-1:0]   w_rsp_next_pc;
  logic                 w_rsp_taken;
  logic                 w_jalr_wait;

  assign ifu_req_valid = (r_state == REQ);
  assign ifu_req_pc    = r_next_pc;
  assign w_req_hs      = ifu_req_valid & ifu_req_ready;
  assign w_rsp_hs      = ifu_rsp_valid & w_rsp_ready;

  // The first fetch address has not been loaded yet in RST_FETCH, so a flush
  // there is neither acknowledged nor acted upon.
  assign w_flush        = pipe_flush_req & (r_state != RST_FETCH);
  assign pipe_flush_ack = w_flush;

  // In WAIT_RSP a response may be taken when the IR slot frees up this cycle.
  // A flush also frees the slot (the IR is invalidated) and the response is
  // dropped anyway. In DRAIN the stale response is swallowed, but not in a
  // cycle that carries a new flush, so DRAIN keeps its "PC update only" role.
  always_comb begin
    w_rsp_ready = 1'b0;
    case (r_state)
      WAIT_RSP: w_rsp_ready = ~r_o_valid | ifu_o_ready | pipe_flush_req;
      DRAIN:    w_rsp_ready = ~pipe_flush_req;
      default:  w_rsp_ready = 1'b0;
    endcase
  end
  assign ifu_rsp_ready = w_rsp_ready;

  assign w_seq_pc = r_req_pc + (dec_rv32 ? c_pc_inc4 : c_pc_inc2);

  // A jalr through a non-zero register whose value is still in flight must
  // wait; bus errors suppress all decode information.
  assign w_jalr_wait = ~ifu_rsp_err & dec_jalr & (dec_jalr_rs1idx != '0) & jalr_rs1_dep;

  // Static next-PC prediction for a response in WAIT_RSP.
  always_comb begin
    w_rsp_next_pc = w_seq_pc;
    w_rsp_taken   = 1'b0;
    if (!ifu_rsp_err) begin
      if (dec_jal) begin
        w_rsp_next_pc = r_req_pc + dec_bjp_imm;
        w_rsp_taken   = 1'b1;
      end else if (dec_jalr) begin
        w_rsp_next_pc = (dec_jalr_rs1idx == '0) ? dec_bjp_imm
                                                : (jalr_rs1_val + dec_bjp_imm);
        w_rsp_taken   = 1'b1;
      end else if (dec_bxx && dec_bjp_imm[PC_SIZE-1]) begin
        // negative offset: backward branch, predicted taken
        w_rsp_next_pc = r_req_pc + dec_bjp_imm;
        w_rsp_taken   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RST_FETCH;
      r_next_pc  <= '0;
      r_req_pc   <= '0;
      r_dep_imm  <= '0;
      r_o_valid  <= 1'b0;
      r_o_ir     <= '0;
      r_o_pc     <= '0;
      r_o_taken  <= 1'b0;
      r_o_buserr <= 1'b0;
    end else begin
      // Consumption by decode; a same-cycle load below re-sets it.
      if (r_o_valid && ifu_o_ready) begin
        r_o_valid <= 1'b0;
      end

      case (r_state)
        RST_FETCH: begin
          r_next_pc <= pc_rtvec;
          r_state   <= REQ;
        end

        REQ: begin
          if (w_flush) begin
            r_next_pc <= pipe_flush_pc;
            // A request accepted in the flush cycle is still outstanding.
            r_state   <= w_req_hs ? DRAIN : REQ;
          end else if (w_req_hs) begin
            r_req_pc <= r_next_pc;
            r_state  <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (w_flush) begin
            r_next_pc <= pipe_flush_pc;
            r_state   <= w_rsp_hs ? REQ : DRAIN;
          end else if (w_rsp_hs) begin
            r_o_valid  <= 1'b1;
            r_o_ir     <= ifu_rsp_instr;
            r_o_pc     <= r_req_pc;
            r_o_taken  <= w_rsp_taken;
            r_o_buserr <= ifu_rsp_err;
            if (w_jalr_wait) begin
              r_dep_imm <= dec_bjp_imm;
              r_state   <= WAIT_DEP;
            end else begin
              r_next_pc <= w_rsp_next_pc;
              r_state   <= REQ;
            end
          end
        end

        WAIT_DEP: begin
          if (w_flush) begin
            r_next_pc <= pipe_flush_pc;
            r_state   <= REQ;
          end else if (!jalr_rs1_dep) begin
            r_next_pc <= jalr_rs1_val + r_dep_imm;
            r_state   <= REQ;
          end
        end

        DRAIN: begin
          if (w_flush) begin
            r_next_pc <= pipe_flush_pc;
          end else if (w_rsp_hs) begin
            r_state <= REQ;
          end
        end

        default: r_state <= RST_FETCH;
      endcase

      // Flush wins over any load or hold of the IR register.
      if (w_flush) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign ifu_o_valid      = r_o_valid;
  assign ifu_o_ir         = r_o_ir;
  assign ifu_o_pc         = r_o_pc;
  assign ifu_o_prdt_taken = r_o_taken;
  assign ifu_o_buserr     = r_o_buserr;

endmodule
`default_nettype wire

// File: tb/tb_e203_ifu_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_ifu_fetch_seq
// Purpose  : Directed bench for e203_ifu_fetch_seq: reset values, sequential
//            fetch, branch/jal/jalr prediction, jalr dependency stall, flush
//            with drain, IR back-pressure, bus error and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_ifu_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_rtvec;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        dec_rv32, dec_jal, dec_jalr, dec_bxx;
  logic [4:0]  dec_jalr_rs1idx;
  logic [31:0] dec_bjp_imm;
  logic [31:0] jalr_rs1_val;
  logic        jalr_rs1_dep;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;
  logic        pipe_flush_ack;
  logic        ifu_o_valid;
  logic        ifu_o_ready;
  logic [31:0] ifu_o_ir;
  logic [31:0] ifu_o_pc;
  logic        ifu_o_prdt_taken;
  logic        ifu_o_buserr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  e203_ifu_fetch_seq #(.PC_SIZE(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .dec_rv32(dec_rv32), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_bjp_imm(dec_bjp_imm),
    .jalr_rs1_val(jalr_rs1_val), .jalr_rs1_dep(jalr_rs1_dep),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
    .ifu_o_prdt_taken(ifu_o_prdt_taken), .ifu_o_buserr(ifu_o_buserr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, then accept it.
  task automatic req_hs(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!ifu_req_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req_valid"}, 64'(ifu_req_valid), 64'd1);
    chk({tag, "_req_pc"}, 64'(ifu_req_pc), 64'(exp_pc));
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
  endtask

  // Present a response with decode info, wait (bounded) for ready, complete it.
  task automatic rsp_hs(input string tag, input logic [31:0] instr, input logic rv32,
                        input logic jal, input logic jalr, input logic bxx,
                        input logic [4:0] idx, input logic [31:0] imm, input logic err);
    int n = 0;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = instr; ifu_rsp_err = err;
    dec_rv32 = rv32; dec_jal = jal; dec_jalr = jalr; dec_bxx = bxx;
    dec_jalr_rs1idx = idx; dec_bjp_imm = imm;
    #1;
    while (!ifu_rsp_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rsp_ready"}, 64'(ifu_rsp_ready), 64'd1);
    step();
    ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    dec_rv32 = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
    dec_jalr_rs1idx = '0; dec_bjp_imm = '0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                         input logic taken, input logic berr);
    chk({tag, "_o_valid"}, 64'(ifu_o_valid), 64'd1);
    chk({tag, "_o_ir"}, 64'(ifu_o_ir), 64'(ir));
    chk({tag, "_o_pc"}, 64'(ifu_o_pc), 64'(pc));
    chk({tag, "_o_taken"}, 64'(ifu_o_prdt_taken), 64'(taken));
    chk({tag, "_o_buserr"}, 64'(ifu_o_buserr), 64'(berr));
  endtask

  task automatic flush(input logic [31:0] pc);
    pipe_flush_req = 1'b1; pipe_flush_pc = pc;
    #1;
    chk("flush_ack", 64'(pipe_flush_ack), 64'd1);
    step();
    pipe_flush_req = 1'b0;
    chk("flush_o_valid", 64'(ifu_o_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; pc_rtvec = 32'h8000_0000;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    dec_rv32 = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
    dec_jalr_rs1idx = '0; dec_bjp_imm = '0; jalr_rs1_val = '0; jalr_rs1_dep = 1'b0;
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h1234; ifu_o_ready = 1'b1;

    // reset values (flush request driven to show no ack during reset)
    step(); step();
    chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("rst_rsp_ready", 64'(ifu_rsp_ready), 64'd0);
    chk("rst_flush_ack", 64'(pipe_flush_ack), 64'd0);
    chk("rst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("rst_o_ir", 64'(ifu_o_ir), 64'd0);
    chk("rst_o_pc", 64'(ifu_o_pc), 64'd0);
    chk("rst_o_flags", {62'd0, ifu_o_prdt_taken, ifu_o_buserr}, 64'd0);
    pipe_flush_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rstfetch_req_valid", 64'(ifu_req_valid), 64'd0);
    step();

    // sequential rv32 fetch from the reset vector
    req_hs("seq0", 32'h8000_0000);
    rsp_hs("seq0", 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk_out("seq0", 32'h0000_0013, 32'h8000_0000, 1'b0, 1'b0);
    req_hs("seq1", 32'h8000_0004);
    rsp_hs("seq1", 32'h0010_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    req_hs("seq2", 32'h8000_0008);
    rsp_hs("seq2", 32'h0020_0113, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // backward bxx at 0x100 -> 0x0F0 taken
    flush(32'h0000_0100);
    req_hs("bxxb", 32'h0000_0100);
    rsp_hs("bxxb", 32'hFE00_08E3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFF0, 1'b0);
    chk_out("bxxb", 32'hFE00_08E3, 32'h0000_0100, 1'b1, 1'b0);
    req_hs("bxxb_tgt", 32'h0000_00F0);
    rsp_hs("nop", 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // forward bxx at 0x100, rv32 -> 0x104 not taken
    flush(32'h0000_0100);
    req_hs("bxxf32", 32'h0000_0100);
    rsp_hs("bxxf32", 32'h0000_0863, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0010, 1'b0);
    chk_out("bxxf32", 32'h0000_0863, 32'h0000_0100, 1'b0, 1'b0);
    req_hs("bxxf32_nxt", 32'h0000_0104);
    rsp_hs("nop", 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // forward bxx at 0x100, rv16 -> 0x102; jal +0x20 -> 0x122; jalr x0 -> 0x300
    flush(32'h0000_0100);
    req_hs("bxxf16", 32'h0000_0100);
    rsp_hs("bxxf16", 32'h0000_C801, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0010, 1'b0);
    req_hs("jal", 32'h0000_0102);
    rsp_hs("jal", 32'h0200_006F, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0020, 1'b0);
    chk_out("jal", 32'h0200_006F, 32'h0000_0102, 1'b1, 1'b0);
    req_hs("jalr0", 32'h0000_0122);
    rsp_hs("jalr0", 32'h3000_0067, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0300, 1'b0);

    // jalr x1 with pending rs1: no request while dependent, then 0x2008
    req_hs("jalrdep", 32'h0000_0300);
    jalr_rs1_dep = 1'b1; jalr_rs1_val = 32'h0000_2000;
    rsp_hs("jalrdep", 32'h0080_8067, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h0000_0008, 1'b0);
    chk_out("jalrdep", 32'h0080_8067, 32'h0000_0300, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("jalrdep_no_req", 64'(ifu_req_valid), 64'd0);
      step();
    end
    jalr_rs1_dep = 1'b0;
    #1;
    chk("jalrdep_still_no_req", 64'(ifu_req_valid), 64'd0);
    step();
    chk("jalrdep_tgt_valid", 64'(ifu_req_valid), 64'd1);
    req_hs("jalrdep_tgt", 32'h0000_2008);
    rsp_hs("nop", 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // flush while waiting for a response: next response is discarded
    req_hs("drain", 32'h0000_200C);
    flush(32'h0000_4000);
    chk("drain_no_req", 64'(ifu_req_valid), 64'd0);
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hDEAD_BEEF; dec_rv32 = 1'b1;
    #1;
    chk("drain_rsp_ready", 64'(ifu_rsp_ready), 64'd1);
    step();
    ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; dec_rv32 = 1'b0;
    chk("drain_o_valid", 64'(ifu_o_valid), 64'd0);
    req_hs("flush_tgt", 32'h0000_4000);

    // back-pressure: IR full and decode not ready holds IR and blocks response
    ifu_o_ready = 1'b0;
    rsp_hs("bp_a", 32'hAAAA_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    req_hs("bp_b", 32'h0000_4004);
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hBBBB_BBBB; ifu_rsp_err = 1'b1;
    dec_rv32 = 1'b0; dec_jal = 1'b1; dec_bjp_imm = 32'h0000_0100;
    #1;
    chk("bp_rsp_ready_lo", 64'(ifu_rsp_ready), 64'd0);
    step();
    chk_out("bp_hold", 32'hAAAA_0013, 32'h0000_4000, 1'b0, 1'b0);
    ifu_o_ready = 1'b1;
    #1;
    chk("bp_rsp_ready_hi", 64'(ifu_rsp_ready), 64'd1);
    step();
    ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    dec_jal = 1'b0; dec_bjp_imm = '0;
    chk_out("buserr", 32'hBBBB_BBBB, 32'h0000_4004, 1'b0, 1'b1);
    req_hs("buserr_seq", 32'h0000_4006);

    // reset mid-transaction: state cleared, no response awaited afterwards
    pc_rtvec = 32'h0000_1000;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("midrst_rsp_ready", 64'(ifu_rsp_ready), 64'd0);
    chk("midrst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("midrst_o_ir", 64'(ifu_o_ir), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    req_hs("midrst_tgt", 32'h0000_1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
